// File: rtl/io_bus_arbiter_if.sv
// Handshake and shared-bus signals between the two requesters, the memory side and the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface io_bus_arbiter_if;
  logic        i_m0_req;
  logic        i_m1_req;
  logic        i_m0_we;
  logic        i_m1_we;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m0_wdata;
  logic [31:0] i_m1_wdata;
  logic [3:0]  i_m0_bmask;
  logic [3:0]  i_m1_bmask;
  logic        o_m0_gnt;
  logic        o_m1_gnt;
  logic        o_m0_rvalid;
  logic        o_m1_rvalid;
  logic [31:0] o_m0_rdata;
  logic [31:0] o_m1_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  modport slave (
    input  i_m0_req, i_m1_req, i_m0_we, i_m1_we,
    input  i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata,
    input  i_m0_bmask, i_m1_bmask, i_mem_rdata,
    output o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid,
    output o_m0_rdata, o_m1_rdata, o_mem_en, o_mem_we,
    output o_mem_addr, o_mem_wdata, o_mem_bmask, o_busy
  );

  modport master (
    output i_m0_req, i_m1_req, i_m0_we, i_m1_we,
    output i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata,
    output i_m0_bmask, i_m1_bmask, i_mem_rdata,
    input  o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid,
    input  o_m0_rdata, o_m1_rdata, o_mem_en, o_mem_we,
    input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_busy
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared load/store bus; one transaction at a time.
// State | meaning: IDLE arbitrate | ISSUE bus strobe + grant | WAIT read latency | RESP return read data.
module io_bus_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  io_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_m0_req || bus.i_m1_req) begin
          // last_q = 1 means m1 was granted most recently, so m0 wins a tie
          if (bus.i_m0_req && bus.i_m1_req) begin
            win_d = ~last_q;
          end else begin
            win_d = bus.i_m1_req;
          end
          last_d  = win_d;
          we_d    = win_d ? bus.i_m1_we    : bus.i_m0_we;
          addr_d  = win_d ? bus.i_m1_addr  : bus.i_m0_addr;
          wdata_d = win_d ? bus.i_m1_wdata : bus.i_m0_wdata;
          bmask_d = win_d ? bus.i_m1_bmask : bus.i_m0_bmask;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = 3'(READ_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
        if (cnt_q <= 3'd1) begin
          if (win_q) begin
            rdata1_d = bus.i_mem_rdata;
          end else begin
            rdata0_d = bus.i_mem_rdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state so every strobe comes straight from a flop
    mem_en_d  = (state_d == ST_ISSUE);
    mem_we_d  = mem_en_d & we_d;
    gnt0_d    = mem_en_d & ~win_d;
    gnt1_d    = mem_en_d & win_d;
    rvalid0_d = (state_d == ST_RESP) & ~win_d;
    rvalid1_d = (state_d == ST_RESP) & win_d;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_m0_gnt    = gnt0_q;
  assign bus.o_m1_gnt    = gnt1_q;
  assign bus.o_m0_rvalid = rvalid0_q;
  assign bus.o_m1_rvalid = rvalid1_q;
  assign bus.o_m0_rdata  = rdata0_q;
  assign bus.o_m1_rdata  = rdata1_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_bmask = bmask_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: READ_LAT=1 and READ_LAT=3 instances, vector table, corner sequences
// and a randomized run against a transaction-timeline reference model.
module tb_io_bus_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } req_t;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        rv0;
    logic        rv1;
    logic        en;
    logic        we;
    logic        busy;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  bm;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } out_t;

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    logic        eg0;
    logic        eg1;
    logic        ebusy2;
    logic        erv0;
    logic        erv1;
    logic [31:0] erd;
    logic [31:0] erdo;
  } vec_t;

  localparam int NR = 1500;

  logic clk;
  logic rst_n;
  req_t drv [2][2];
  logic [31:0] rdv [2];
  out_t out1, out3;
  int n_chk;
  int n_fail;

  io_bus_arbiter_if if1 ();
  io_bus_arbiter_if if3 ();

  io_bus_arbiter #(.READ_LAT(1)) dut1 (.i_clk(clk), .i_reset(rst_n), .bus(if1));
  io_bus_arbiter #(.READ_LAT(3)) dut3 (.i_clk(clk), .i_reset(rst_n), .bus(if3));

  assign if1.i_m0_req    = drv[0][0].req;
  assign if1.i_m0_we     = drv[0][0].we;
  assign if1.i_m0_addr   = drv[0][0].addr;
  assign if1.i_m0_wdata  = drv[0][0].wdata;
  assign if1.i_m0_bmask  = drv[0][0].bmask;
  assign if1.i_m1_req    = drv[0][1].req;
  assign if1.i_m1_we     = drv[0][1].we;
  assign if1.i_m1_addr   = drv[0][1].addr;
  assign if1.i_m1_wdata  = drv[0][1].wdata;
  assign if1.i_m1_bmask  = drv[0][1].bmask;
  assign if1.i_mem_rdata = rdv[0];
  assign if3.i_m0_req    = drv[1][0].req;
  assign if3.i_m0_we     = drv[1][0].we;
  assign if3.i_m0_addr   = drv[1][0].addr;
  assign if3.i_m0_wdata  = drv[1][0].wdata;
  assign if3.i_m0_bmask  = drv[1][0].bmask;
  assign if3.i_m1_req    = drv[1][1].req;
  assign if3.i_m1_we     = drv[1][1].we;
  assign if3.i_m1_addr   = drv[1][1].addr;
  assign if3.i_m1_wdata  = drv[1][1].wdata;
  assign if3.i_m1_bmask  = drv[1][1].bmask;
  assign if3.i_mem_rdata = rdv[1];

  assign out1 = {if1.o_m0_gnt, if1.o_m1_gnt, if1.o_m0_rvalid, if1.o_m1_rvalid, if1.o_mem_en,
                 if1.o_mem_we, if1.o_busy, if1.o_mem_addr, if1.o_mem_wdata, if1.o_mem_bmask,
                 if1.o_m0_rdata, if1.o_m1_rdata};
  assign out3 = {if3.o_m0_gnt, if3.o_m1_gnt, if3.o_m0_rvalid, if3.o_m1_rvalid, if3.o_mem_en,
                 if3.o_mem_we, if3.o_busy, if3.o_mem_addr, if3.o_mem_wdata, if3.o_mem_bmask,
                 if3.o_m0_rdata, if3.o_m1_rdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=time limit reached required=finish before limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic out_t get_out(input int d);
    return (d == 0) ? out1 : out3;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      rdv[i] = 32'd0;
      for (int j = 0; j < 2; j++) drv[i][j] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm, input out_t o);
    chk({nm, "_gnt"}, {30'd0, o.g1, o.g0}, 32'd0);
    chk({nm, "_rvalid"}, {30'd0, o.rv1, o.rv0}, 32'd0);
    chk({nm, "_en_we_busy"}, {29'd0, o.en, o.we, o.busy}, 32'd0);
    chk({nm, "_addr"}, o.addr, 32'd0);
    chk({nm, "_wdata_bmask"}, o.wd | {28'd0, o.bm}, 32'd0);
    chk({nm, "_rdata"}, o.rd0 | o.rd1, 32'd0);
  endtask

  // Timeline reference model: expected outputs per cycle, scheduled when a grant is decided
  bit          e_g0 [NR+16];
  bit          e_g1 [NR+16];
  bit          e_en [NR+16];
  bit          e_we [NR+16];
  bit          e_rv0 [NR+16];
  bit          e_rv1 [NR+16];
  bit          e_busy [NR+16];
  logic [31:0] e_addr [NR+16];
  logic [31:0] e_wd [NR+16];
  logic [3:0]  e_bm [NR+16];
  int          cap_at [NR+16];
  logic [31:0] mem_at [NR+16];

  task automatic run_random(input int d, input int lat);
    bit          pend [2];
    req_t        cmd [2];
    bit          last;
    int          free_at;
    int          w;
    logic [31:0] m_rd [2];
    logic [31:0] cur_addr, cur_wd;
    logic [3:0]  cur_bm;
    out_t        o;
    for (int i = 0; i < NR + 16; i++) begin
      e_g0[i] = 0; e_g1[i] = 0; e_en[i] = 0; e_we[i] = 0;
      e_rv0[i] = 0; e_rv1[i] = 0; e_busy[i] = 0;
      e_addr[i] = '0; e_wd[i] = '0; e_bm[i] = '0; cap_at[i] = 0; mem_at[i] = '0;
    end
    pend[0] = 0; pend[1] = 0; cmd[0] = '0; cmd[1] = '0;
    last = 1; free_at = 0; m_rd[0] = '0; m_rd[1] = '0;
    cur_addr = '0; cur_wd = '0; cur_bm = '0;
    for (int k = 0; k < NR; k++) begin
      o = get_out(d);
      if (e_rv0[k]) m_rd[0] = mem_at[cap_at[k]];
      if (e_rv1[k]) m_rd[1] = mem_at[cap_at[k]];
      chk("rnd_gnt0", o.g0, e_g0[k]);
      chk("rnd_gnt1", o.g1, e_g1[k]);
      chk("rnd_mem_en", o.en, e_en[k]);
      chk("rnd_mem_we", o.we, e_we[k]);
      chk("rnd_rvalid0", o.rv0, e_rv0[k]);
      chk("rnd_rvalid1", o.rv1, e_rv1[k]);
      chk("rnd_busy", o.busy, e_busy[k]);
      chk("rnd_addr", o.addr, e_addr[k]);
      chk("rnd_wdata", o.wd, e_wd[k]);
      chk("rnd_bmask", o.bm, e_bm[k]);
      chk("rnd_rdata0", o.rd0, m_rd[0]);
      chk("rnd_rdata1", o.rd1, m_rd[1]);

      mem_at[k] = $urandom;
      rdv[d] = mem_at[k];
      for (int j = 0; j < 2; j++) begin
        if (!pend[j] && $urandom_range(0, 2) == 0) begin
          pend[j] = 1;
          cmd[j] = '{1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom)};
        end
        if (pend[j]) drv[d][j] = cmd[j];
        else drv[d][j] = '{1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom)};
      end

      if (k >= free_at && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = last ? 0 : 1;
        else w = pend[1] ? 1 : 0;
        last = (w == 1);
        if (w == 0) e_g0[k+1] = 1;
        else e_g1[k+1] = 1;
        e_en[k+1] = 1;
        e_we[k+1] = cmd[w].we;
        cur_addr = cmd[w].addr;
        cur_wd = cmd[w].wdata;
        cur_bm = cmd[w].bmask;
        free_at = cmd[w].we ? k + 2 : k + lat + 3;
        for (int c = k + 1; c < free_at; c++) e_busy[c] = 1;
        if (!cmd[w].we) begin
          if (w == 0) e_rv0[k+lat+2] = 1;
          else e_rv1[k+lat+2] = 1;
          cap_at[k+lat+2] = k + 1 + lat;
        end
        pend[w] = 0;
      end
      e_addr[k+1] = cur_addr;
      e_wd[k+1] = cur_wd;
      e_bm[k+1] = cur_bm;
      @(negedge clk);
    end
    clear_inputs();
    for (int i = 0; i < 12; i++) @(negedge clk);
  endtask

  vec_t vecs [5];
  out_t o;
  int   ng, nrv, cnt;
  logic lastg;
  logic order [4];

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{1'b0, 1'b0, 32'h1000_7000, 32'h0000_0000, 4'hF, 32'h0000_00A5,
                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00A5, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h1000_7010, 32'h0000_00FF, 4'hF, 32'hDEAD_BEEF,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_00A5};
    vecs[2] = '{1'b1, 1'b0, 32'h2000_0004, 32'h1111_1111, 4'h0, 32'h5555_AAAA,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5555_AAAA, 32'h0000_00A5};
    vecs[3] = '{1'b0, 1'b1, 32'h3000_0008, 32'h0102_0304, 4'h3, 32'h0000_0077,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00A5, 32'h5555_AAAA};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF,
                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h5555_AAAA};

    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_dut1", out1);
    chk_all_zero("reset_dut3", out3);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_dut1", out1);

    // Single-transaction vectors on the READ_LAT=1 instance; each starts from IDLE (t0)
    for (int v = 0; v < 5; v++) begin
      drv[0][vecs[v].m] = '{1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].bmask};
      drv[0][~vecs[v].m] = '0;
      rdv[0] = 32'hDEAD_0000;
      @(negedge clk);
      o = get_out(0);
      chk("vec_t1_gnt0", o.g0, vecs[v].eg0);
      chk("vec_t1_gnt1", o.g1, vecs[v].eg1);
      chk("vec_t1_mem_en", o.en, 1'b1);
      chk("vec_t1_mem_we", o.we, vecs[v].we);
      chk("vec_t1_addr", o.addr, vecs[v].addr);
      chk("vec_t1_wdata", o.wd, vecs[v].wdata);
      chk("vec_t1_bmask", o.bm, vecs[v].bmask);
      chk("vec_t1_rvalid", {o.rv1, o.rv0}, 2'b00);
      drv[0][vecs[v].m].req = 1'b0;
      @(negedge clk);
      o = get_out(0);
      rdv[0] = vecs[v].rdata;
      chk("vec_t2_mem_en_we", {o.en, o.we}, 2'b00);
      chk("vec_t2_gnt", {o.g1, o.g0}, 2'b00);
      chk("vec_t2_busy", o.busy, vecs[v].ebusy2);
      chk("vec_t2_addr", o.addr, vecs[v].addr);
      @(negedge clk);
      o = get_out(0);
      rdv[0] = 32'hDEAD_0001;
      chk("vec_t3_rvalid0", o.rv0, vecs[v].erv0);
      chk("vec_t3_rvalid1", o.rv1, vecs[v].erv1);
      chk("vec_t3_rdata", vecs[v].m ? o.rd1 : o.rd0, vecs[v].erd);
      chk("vec_t3_rdata_other", vecs[v].m ? o.rd0 : o.rd1, vecs[v].erdo);
      chk("vec_t3_addr", o.addr, vecs[v].addr);
      @(negedge clk);
      o = get_out(0);
      chk("vec_t4_idle", {o.busy, o.rv1, o.rv0, o.en}, 4'b0000);
    end

    // Round-robin: both requesters read continuously
    do_reset();
    drv[0][0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF};
    drv[0][1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF};
    rdv[0] = 32'h0BAD_F00D;
    ng = 0; nrv = 0; lastg = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      o = get_out(0);
      chk("rr_one_gnt", o.g0 & o.g1, 1'b0);
      if (o.g0 || o.g1) begin
        if (ng < 4) order[ng] = o.g1;
        ng++;
        lastg = o.g1;
        chk("rr_gnt_addr", o.addr, o.g1 ? 32'h0000_0200 : 32'h0000_0100);
      end
      if (o.rv0 || o.rv1) begin
        nrv++;
        chk("rr_rvalid_owner", o.rv1, lastg);
      end
    end
    clear_inputs();
    chk("rr_gnt_count", ng, 5);
    chk("rr_rvalid_count", nrv, 5);
    for (int i = 0; i < 4; i++) chk("rr_order", order[i], (i % 2) == 1);
    for (int i = 0; i < 4; i++) @(negedge clk);

    // m1 write followed by an m0 request raised during ISSUE
    do_reset();
    drv[0][1] = '{1'b1, 1'b1, 32'h1000_7010, 32'h0000_00FF, 4'hF};
    @(negedge clk);
    o = get_out(0);
    chk("wr_t1_gnt1", {o.g1, o.g0}, 2'b10);
    chk("wr_t1_en_we", {o.en, o.we}, 2'b11);
    chk("wr_t1_addr", o.addr, 32'h1000_7010);
    chk("wr_t1_wdata", o.wd, 32'h0000_00FF);
    chk("wr_t1_bmask", o.bm, 4'hF);
    drv[0][1] = '0;
    drv[0][0] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF};
    @(negedge clk);
    o = get_out(0);
    chk("wr_t2_quiet", {o.en, o.we, o.g0, o.g1, o.rv0, o.rv1}, 6'd0);
    @(negedge clk);
    o = get_out(0);
    chk("wr_t3_gnt0", {o.g1, o.g0}, 2'b01);
    chk("wr_t3_en_we", {o.en, o.we}, 2'b10);
    chk("wr_t3_no_rvalid1", o.rv1, 1'b0);
    drv[0][0] = '0;
    for (int i = 0; i < 4; i++) @(negedge clk);

    // READ_LAT=3 read: rdata valid only in t4
    do_reset();
    rdv[1] = 32'hBAD0_BAD0;
    drv[1][0] = '{1'b1, 1'b0, 32'h1000_7800, 32'h0, 4'hF};
    @(negedge clk);
    o = get_out(1);
    chk("l3_t1_gnt0", {o.g1, o.g0, o.en}, 3'b011);
    chk("l3_t1_addr", o.addr, 32'h1000_7800);
    drv[1][0] = '0;
    for (int t = 2; t <= 3; t++) begin
      @(negedge clk);
      o = get_out(1);
      chk("l3_wait_addr", o.addr, 32'h1000_7800);
      chk("l3_wait_quiet", {o.en, o.rv0, o.busy}, 3'b001);
    end
    @(negedge clk);
    o = get_out(1);
    rdv[1] = 32'h1234_5678;
    chk("l3_t4_addr", o.addr, 32'h1000_7800);
    chk("l3_t4_no_rvalid", o.rv0, 1'b0);
    @(negedge clk);
    o = get_out(1);
    rdv[1] = 32'hBAD0_BAD0;
    chk("l3_t5_addr", o.addr, 32'h1000_7800);
    chk("l3_t5_rvalid", {o.rv1, o.rv0}, 2'b01);
    chk("l3_t5_rdata", o.rd0, 32'h1234_5678);
    @(negedge clk);
    o = get_out(1);
    chk("l3_t6_idle", {o.busy, o.rv0}, 2'b00);
    chk("l3_t6_rdata_hold", o.rd0, 32'h1234_5678);

    // Reset asserted in the second WAIT cycle of a READ_LAT=3 read
    drv[1][0] = '{1'b1, 1'b0, 32'h1000_7900, 32'h0, 4'hF};
    @(negedge clk);
    drv[1][0] = '0;
    @(negedge clk);
    @(negedge clk);
    o = get_out(1);
    chk("rst_pre_busy", o.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_read", get_out(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = get_out(1);
      chk("rst_after_quiet", {o.busy, o.rv0, o.rv1}, 3'b000);
    end
    drv[1][0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF};
    drv[1][1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF};
    @(negedge clk);
    o = get_out(1);
    chk("rst_tie_gnt0", {o.g1, o.g0}, 2'b01);
    drv[1][0] = '0;
    drv[1][1] = '0;
    for (int i = 0; i < 6; i++) @(negedge clk);

    // m1 read whose request drops in the ISSUE cycle
    rdv[1] = 32'hCAFE_F00D;
    drv[1][1] = '{1'b1, 1'b0, 32'h1000_7A00, 32'h0, 4'hF};
    @(negedge clk);
    drv[1][1] = '0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      o = get_out(1);
      if (o.rv1) cnt++;
    end
    chk("drop_rvalid1_count", cnt, 1);
    chk("drop_rdata1", o.rd1, 32'hCAFE_F00D);

    do_reset();
    run_random(0, 1);
    do_reset();
    run_random(1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-requester arbiter and sequencer for the shared load/store path into data memory and the memory-mapped I/O buffers. Requester 0 is the core LSU and requester 1 is the debug/DMA port. It grants one transaction at a time, round-robin, and drives the shared address/command bus. It holds the address stable for the full read latency so the downstream load-data multiplexer decodes a steady address. It then returns the captured read data to the granted requester.

## Interface
Parameters:
- READ_LAT, 1, cycles from the mem-enable cycle to valid `i_mem_rdata`; legal range 1..7.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_m0_req / i_m1_req  input  1  transaction request.
- i_m0_we / i_m1_we  input  1  1 = write, 0 = read.
- i_m0_addr / i_m1_addr  input  32  byte address.
- i_m0_wdata / i_m1_wdata  input  32  write data.
- i_m0_bmask / i_m1_bmask  input  4  byte-lane enables.
- o_m0_gnt / o_m1_gnt  output  1  one-cycle grant pulse.
- o_m0_rvalid / o_m1_rvalid  output  1  one-cycle read-data-valid pulse.
- o_m0_rdata / o_m1_rdata  output  32  read data; holds its value until the next rvalid to that requester.
- o_mem_en  output  1  shared-bus access strobe.
- o_mem_we  output  1  write strobe; equals o_mem_en AND the latched we.
- o_mem_addr  output  32  latched address.
- o_mem_wdata  output  32  latched write data.
- o_mem_bmask  output  4  latched byte mask.
- i_mem_rdata  input  32  muxed load data (DMEM or I/O).
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req is high, pick a winner, latch its we/addr/wdata/bmask, record the winner index, update the RR pointer, and go to ISSUE.
  - If no req is high, stay in IDLE.
- **Winner selection**
  - If only one requester is requesting, it wins.
  - If both are requesting, the winner is the requester not granted most recently.
  - The RR pointer resets to "last = m1", so m0 wins the first tie.
- **ISSUE** (exactly 1 cycle)
  - o_mem_en = 1.
  - o_mX_gnt = 1 for the winner only.
  - A write goes to IDLE next. Writes produce no rvalid.
  - A read loads the latency counter with READ_LAT and goes to WAIT.
- **WAIT** (READ_LAT cycles)
  - The counter decrements each cycle.
  - In the last WAIT cycle (counter = 1), capture i_mem_rdata into the winner's rdata register and go to RESP.
- **RESP** (1 cycle): o_mX_rvalid = 1 for the winner. Next state is IDLE.
- **Address hold**: o_mem_addr, o_mem_wdata and o_mem_bmask hold the latched values from ISSUE through RESP, and stay unchanged until the next latch.
- **Requester obligations**
  - Hold req and the command stable until gnt.
  - After the IDLE→ISSUE edge, input changes are ignored.
  - A req dropped during ISSUE or WAIT does not cancel the transaction; it completes normally.
- **Counter**: 3 bits wide; it never underflows.

## Timing
- All outputs are registered.
- Reset values:
  - Every output is 0.
  - State = IDLE, counter = 0, pointer = m1.
  - Latched command = 0.
- Reset is asynchronous. Asserting it mid-transaction forces outputs to 0 immediately and aborts the transaction. No rvalid is issued after release.
- **Write timing**: req sampled in cycle t0 → gnt and mem write in t1 → next arbitration in t2. Write throughput is 1 per 2 cycles.
- **Read timing**: req sampled in t0 → gnt and mem_en in t1 → WAIT from t2 to t1+READ_LAT → rvalid in t0+READ_LAT+2 → IDLE in t0+READ_LAT+3.
- i_mem_rdata must be valid in cycle t1+READ_LAT. The arbiter samples it at the end of that cycle.
- gnt and rvalid are never asserted to both requesters in the same cycle. At most one transaction is outstanding.

## Test plan
- **Single read, READ_LAT=1**: m0 reads 0x1000_7000; the model drives i_mem_rdata = 0x0000_00A5 in t2. Required: gnt in t1, mem_en=1 and we=0 in t1, addr = 0x1000_7000 during t1–t3, o_m0_rvalid in t3 with rdata 0xA5, and all m1 outputs stay 0.
- **Round-robin**: both requesters continuously request reads after reset. Required: grant order m0, m1, m0, m1; each rvalid goes to the matching requester; no cycle has two gnts.
- **Write**: m1 writes 0x1000_7010 with wdata 0x0000_00FF and bmask 0xF. Required: mem_en and mem_we high for exactly one cycle (t1) with those values, no rvalid, and a pending m0 request granted in t3.
- **READ_LAT=3 instance**: m0 reads 0x1000_7800; i_mem_rdata = 0x1234_5678 in t4. Required: o_mem_addr stable during t1–t5, and o_m0_rvalid in t5 with rdata 0x1234_5678.
- **Reset mid-read**: assert i_reset in the second WAIT cycle. Required: all outputs 0 immediately; after release, no rvalid appears, o_busy is 0, and a new m1/m0 tie grants m0.
- **Dropped request**: m1 read where i_m1_req falls in the ISSUE cycle. Required: the transaction still completes and o_m1_rvalid pulses once.
